// File: rtl/edge_mon_pkg.sv
// ----------------------------------------------------------------------------
// edge_mon_pkg
//   Shared types for the edge_monitor block.
//   err_e        : per-channel first-error code, reported on err_code.
//   chan_state_e : per-channel checker state.
// ----------------------------------------------------------------------------
package edge_mon_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_EARLY   = 2'd1,
        ERR_SHORT   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAIL  = 2'd2
    } chan_state_e;

endpackage : edge_mon_pkg

// File: rtl/edge_mon_chan.sv
// ----------------------------------------------------------------------------
// edge_mon_chan
//   One monitored channel: checker FSM, saturating interval counter,
//   saturating edge counter and first-error capture.
//   Optional feature macro: EDGE_MON_TIMEOUT_EN (ARMED channel fails with
//   ERR_TIMEOUT when no edge arrives within MAX_PERIOD cycles).
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_rise       : rising edge seen on this channel this cycle
//   i_in_guard   : post-reset guard window active
//   i_clear      : synchronous soft clear (wins over i_rise)
//   o_fail       : sticky fail, registered
//   o_fail_nxt   : value o_fail takes at the next edge (feeds the pass flag)
//   o_err        : first error code, registered
//   o_cnt        : saturating rising-edge count
// ----------------------------------------------------------------------------
module edge_mon_chan
    import edge_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int GAP_W      = 16,
    parameter int MIN_PERIOD = 2,
    parameter int MAX_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rise,
    input  logic             i_in_guard,
    input  logic             i_clear,
    output logic             o_fail,
    output logic             o_fail_nxt,
    output err_e             o_err,
    output logic [CNT_W-1:0] o_cnt
);

    if (MIN_PERIOD < 1 || longint'(MAX_PERIOD) >= (longint'(1) << GAP_W)) begin : g_bad_cfg
        $error("edge_mon_chan: need MIN_PERIOD >= 1 and MAX_PERIOD < 2**GAP_W");
    end

    // Compared against gap+1, so one bit wider than the gap counter.
    localparam logic [GAP_W:0] MIN_GAP = (GAP_W+1)'(MIN_PERIOD);

    chan_state_e       r_state;
    logic [GAP_W-1:0]  r_gap;
    err_e              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fail;

    logic [GAP_W:0]    w_gap_p1;
    logic              w_early;
    logic              w_short;
    logic              w_timeout;

    assign w_gap_p1 = {1'b0, r_gap} + (GAP_W+1)'(1);
    assign w_early  = (r_state == IDLE)  && i_rise && i_in_guard;
    assign w_short  = (r_state == ARMED) && i_rise && (w_gap_p1 < MIN_GAP);

`ifdef EDGE_MON_TIMEOUT_EN
    localparam logic [GAP_W:0] MAX_GAP = (GAP_W+1)'(MAX_PERIOD);
    assign w_timeout = (r_state == ARMED) && !i_rise && (w_gap_p1 == MAX_GAP);
`else
    assign w_timeout = 1'b0;
`endif

    // Lets the top register pass in the same cycle fail_ch rises.
    assign o_fail_nxt = !i_clear && (r_fail || w_early || w_short || w_timeout);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gap   <= '0;
            r_err   <= ERR_NONE;
            r_cnt   <= '0;
            r_fail  <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_gap   <= '0;
            r_err   <= ERR_NONE;
            r_cnt   <= '0;
            r_fail  <= 1'b0;
        end else begin
            // Edges are counted in every state, including FAIL.
            if (i_rise && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            unique case (r_state)
                IDLE: begin
                    if (w_early) begin
                        r_state <= FAIL;
                        r_err   <= ERR_EARLY;
                        r_fail  <= 1'b1;
                    end else if (i_rise) begin
                        r_state <= ARMED;
                        r_gap   <= '0;
                    end
                end
                ARMED: begin
                    if (w_short) begin
                        r_state <= FAIL;
                        r_err   <= ERR_SHORT;
                        r_fail  <= 1'b1;
                    end else if (i_rise) begin
                        r_gap   <= '0;
                    end else if (w_timeout) begin
                        r_state <= FAIL;
                        r_err   <= ERR_TIMEOUT;
                        r_fail  <= 1'b1;
                    end else if (r_gap != {GAP_W{1'b1}}) begin
                        r_gap   <= r_gap + GAP_W'(1);
                    end
                end
                FAIL: begin
                    // Sticky: only clear or reset leave this state, so
                    // r_err keeps the first error.
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_fail = r_fail;
    assign o_err  = r_err;
    assign o_cnt  = r_cnt;

endmodule : edge_mon_chan

// File: rtl/edge_monitor.sv
// ----------------------------------------------------------------------------
// edge_monitor
//   Multi-channel rising-edge checker. Counts rising edges per channel,
//   flags edges inside the post-reset guard window and edge intervals shorter
//   than MIN_PERIOD, and drives a registered aggregate pass flag.
//   Optional feature macro: EDGE_MON_TIMEOUT_EN (interval longer than
//   MAX_PERIOD is an error; otherwise MAX_PERIOD is ignored).
// Ports
//   clk      : sampling clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sig_i    : N_CH monitored strobes, synchronous to clk
//   clear    : synchronous soft clear of counts and errors
//   pass     : 1 = no channel has failed (registered)
//   fail_ch  : per-channel sticky fail
//   err_code : per-channel first error (err_e), ch i at [2i+1:2i]
//   edge_cnt : per-channel saturating edge count, ch i at [CNT_W*i +: CNT_W]
// ----------------------------------------------------------------------------
module edge_monitor
    import edge_mon_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int GAP_W      = 16,
    parameter int GUARD      = 1,
    parameter int MIN_PERIOD = 2,
    parameter int MAX_PERIOD = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       sig_i,
    input  logic                  clear,
    output logic                  pass,
    output logic [N_CH-1:0]       fail_ch,
    output logic [2*N_CH-1:0]     err_code,
    output logic [CNT_W*N_CH-1:0] edge_cnt
);

    if (N_CH < 1 || GUARD < 0) begin : g_bad_cfg
        $error("edge_monitor: need N_CH >= 1 and GUARD >= 0");
    end

    localparam int GUARD_W = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [GUARD_W-1:0] GUARD_END = GUARD_W'(GUARD);

    logic [N_CH-1:0]    r_sig_q;
    logic [GUARD_W-1:0] r_guard_cnt;
    logic               r_pass;

    logic [N_CH-1:0]    w_rise;
    logic [N_CH-1:0]    w_fail_nxt;
    logic               w_in_guard;

    assign w_rise     = sig_i & ~r_sig_q;
    assign w_in_guard = (r_guard_cnt < GUARD_END);

    // r_sig_q resets high so a level already high at reset release is not an
    // edge. The guard counter ignores clear: the window is tied to reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_q     <= '1;
            r_guard_cnt <= '0;
            r_pass      <= 1'b1;
        end else begin
            r_sig_q <= sig_i;
            if (w_in_guard) begin
                r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
            end
            r_pass <= ~|w_fail_nxt;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        err_e w_err;

        edge_mon_chan #(
            .CNT_W      (CNT_W),
            .GAP_W      (GAP_W),
            .MIN_PERIOD (MIN_PERIOD),
            .MAX_PERIOD (MAX_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_rise     (w_rise[i]),
            .i_in_guard (w_in_guard),
            .i_clear    (clear),
            .o_fail     (fail_ch[i]),
            .o_fail_nxt (w_fail_nxt[i]),
            .o_err      (w_err),
            .o_cnt      (edge_cnt[CNT_W*i +: CNT_W])
        );

        assign err_code[2*i +: 2] = w_err;
    end

    assign pass = r_pass;

endmodule : edge_monitor

// File: tb/tb_edge_monitor.sv
// ----------------------------------------------------------------------------
// tb_edge_monitor
//   Directed bench for edge_monitor. Two instances share clk and rst_n:
//     dut   : N_CH=4, CNT_W=16, GUARD=4, MIN_PERIOD=2, MAX_PERIOD=8
//     dut_s : N_CH=1, CNT_W=3,  GUARD=1, MIN_PERIOD=3, MAX_PERIOD=100
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so they reflect the edge that consumed the previous inputs.
//   Timeout checks depend on EDGE_MON_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_edge_monitor;
    import edge_mon_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [3:0]  sig;
    logic        clear;
    logic        pass;
    logic [3:0]  fail_ch;
    logic [7:0]  err_code;
    logic [63:0] edge_cnt;

    logic [0:0]  sig_s;
    logic        clear_s;
    logic        pass_s;
    logic [0:0]  fail_s;
    logic [1:0]  err_s;
    logic [2:0]  cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    edge_monitor #(
        .N_CH(4), .CNT_W(16), .GAP_W(16), .GUARD(4), .MIN_PERIOD(2), .MAX_PERIOD(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_i    (sig),
        .clear    (clear),
        .pass     (pass),
        .fail_ch  (fail_ch),
        .err_code (err_code),
        .edge_cnt (edge_cnt)
    );

    edge_monitor #(
        .N_CH(1), .CNT_W(3), .GAP_W(8), .GUARD(1), .MIN_PERIOD(3), .MAX_PERIOD(100)
    ) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_i    (sig_s),
        .clear    (clear_s),
        .pass     (pass_s),
        .fail_ch  (fail_s),
        .err_code (err_s),
        .edge_cnt (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] cnt_of(input int ch);
        return edge_cnt[16*ch +: 16];
    endfunction

    initial begin
        rst_n   = 1'b0;
        sig     = 4'h0;
        clear   = 1'b0;
        sig_s   = 1'b0;
        clear_s = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_pass",   pass,     1);
        check("rst_fail",   fail_ch,  0);
        check("rst_err",    err_code, 0);
        check("rst_cnt",    edge_cnt, 0);
        check("rst_pass_s", pass_s,   1);
        check("rst_cnt_s",  cnt_s,    0);

        // Release; edge e1 (guard_cnt 0), then ch0 rises at e2 (guard_cnt 1)
        rst_n = 1'b1;
        tick();
        sig[0] = 1'b1;
        tick();
        check("early_fail", fail_ch,       4'b0001);
        check("early_err",  err_code[1:0], ERR_EARLY);
        check("early_pass", pass,          0);
        check("early_cnt0", cnt_of(0),     1);

        // Soft clear at e3
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pass", pass,     1);
        check("clr_fail", fail_ch,  0);
        check("clr_err",  err_code, 0);
        check("clr_cnt",  edge_cnt, 0);

        // e4 still in guard; ch1 first rise at e5 is the first legal edge
        tick();
        for (int k = 0; k < 10; k++) begin
            sig[1] = 1'b1;
            tick();
            check($sformatf("per4_pass%0d", k), pass, 1);
            sig[1] = 1'b0;
            tick();
            tick();
            tick();
        end
        check("per4_cnt1", cnt_of(1), 10);
        check("per4_fail", fail_ch,   0);
        check("per4_err",  err_code,  0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr2_cnt1", cnt_of(1), 0);

        // ch2: interval of 2 equals MIN_PERIOD and is legal
        sig[2] = 1'b1;
        tick();
        sig[2] = 1'b0;
        tick();
        sig[2] = 1'b1;
        tick();
        check("min_iv_fail", fail_ch,   0);
        check("min_iv_cnt2", cnt_of(2), 2);

        // clear together with a ch3 rise: clear wins
        sig[3] = 1'b1;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        check("clr_rise_cnt", edge_cnt, 0);
        check("clr_rise_fail", fail_ch, 0);
        tick();
        check("clr_sigq_cnt3", cnt_of(3), 0);
        sig[3] = 1'b0;
        tick();
        sig[3] = 1'b1;
        tick();
        check("post_clr_cnt3a", cnt_of(3), 1);
        sig[3] = 1'b0;
        tick();
        sig[3] = 1'b1;
        tick();
        check("post_clr_cnt3b", cnt_of(3), 2);
        check("post_clr_fail",  fail_ch,   0);
        check("post_clr_pass",  pass,      1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr3_cnt", edge_cnt, 0);

        // Timeout: ch0 armed at edge R, then held low
        sig[0] = 1'b0;
        tick();
        sig[0] = 1'b1;
        tick();
        sig[0] = 1'b0;
        repeat (7) tick();
        check("to_before", fail_ch, 0);
        tick();
`ifdef EDGE_MON_TIMEOUT_EN
        check("to_fail", fail_ch,       4'b0001);
        check("to_err",  err_code[1:0], ERR_TIMEOUT);
        check("to_pass", pass,          0);
        sig[0] = 1'b1;
        tick();
        check("to_sticky_cnt0", cnt_of(0),     2);
        check("to_sticky_err",  err_code[1:0], ERR_TIMEOUT);
`else
        check("no_to_fail", fail_ch, 0);
        check("no_to_pass", pass,    1);
        repeat (40) tick();
        check("no_to_late", fail_ch, 0);
`endif

        // dut_s: MIN_PERIOD=3, interval 2 is short
        sig_s = 1'b1;
        tick();
        sig_s = 1'b0;
        tick();
        sig_s = 1'b1;
        tick();
        check("short_fail", fail_s, 1);
        check("short_err",  err_s,  ERR_SHORT);
        check("short_cnt",  cnt_s,  2);
        check("short_pass", pass_s, 0);
        sig_s = 1'b0;
        tick();
        sig_s = 1'b1;
        tick();
        check("short_sticky_cnt", cnt_s, 3);
        check("short_sticky_err", err_s, ERR_SHORT);

        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        check("clr_s_pass", pass_s, 1);
        check("clr_s_cnt",  cnt_s,  0);
        sig_s = 1'b0;
        tick();

        // 9 legal edges into a 3-bit counter: saturates at 7
        for (int k = 0; k < 9; k++) begin
            sig_s = 1'b1;
            tick();
            sig_s = 1'b0;
            tick();
            tick();
            tick();
        end
        check("sat_cnt",  cnt_s,  7);
        check("sat_fail", fail_s, 0);

        // Mid-run async reset with all strobes high
        sig   = 4'hF;
        sig_s = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pass",  pass,     1);
        check("arst_fail",  fail_ch,  0);
        check("arst_err",   err_code, 0);
        check("arst_cnt",   edge_cnt, 0);
        check("arst_cnt_s", cnt_s,    0);
        check("arst_err_s", err_s,    0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        // Levels high through release are not edges, so no guard error
        check("rel_hi_cnt",    edge_cnt, 0);
        check("rel_hi_fail",   fail_ch,  0);
        check("rel_hi_cnt_s",  cnt_s,    0);
        check("rel_hi_fail_s", fail_s,   0);
        check("rel_hi_pass",   pass,     1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_edge_monitor
